// File: rtl/slave_addr_decoder.sv
// rtl/slave_addr_decoder.sv - programmable registered slave address decoder
//
// Holds SLAVE_NUM base/limit regions written through a lockable config port.
// Decodes request addresses through one valid/ready register stage into a
// one-hot slave select, binary index and decode-error flag, and counts misses.
//
// Optional feature macro: ADDR_DECODE_HIT_CNT_EN (per-region hit counters).
//
// Ports:
//   ACLK, ARESETn          clock, asynchronous active-low reset
//   cfg_we/idx/base/limit/en  region table write (ignored once locked)
//   cfg_lock, cfg_locked   sticky table lock request / status
//   req_*                  address request (valid/ready, addr, id)
//   dec_*                  registered decode result (valid/ready, sel, idx, err, addr, id)
//   err_clr, err_cnt       saturating miss counter and its clear
//   hit_cnt                per-region saturating hit counters (0 when disabled)

module slave_addr_decoder #(
    parameter int SLAVE_NUM = 8,
    parameter int ADDR_W    = 32,
    parameter int ID_W      = 4,
    parameter int CNT_W     = 16,
    localparam int IDX_W    = $clog2(SLAVE_NUM)
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic                       cfg_we,
    input  logic [IDX_W-1:0]           cfg_idx,
    input  logic [ADDR_W-1:0]          cfg_base,
    input  logic [ADDR_W-1:0]          cfg_limit,
    input  logic                       cfg_en,
    input  logic                       cfg_lock,
    output logic                       cfg_locked,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [ID_W-1:0]            req_id,
    output logic                       dec_valid,
    input  logic                       dec_ready,
    output logic [SLAVE_NUM-1:0]       dec_sel,
    output logic [IDX_W-1:0]           dec_idx,
    output logic                       dec_err,
    output logic [ADDR_W-1:0]          dec_addr,
    output logic [ID_W-1:0]            dec_id,
    input  logic                       err_clr,
    output logic [CNT_W-1:0]           err_cnt,
    output logic [SLAVE_NUM*CNT_W-1:0] hit_cnt
);

    logic [ADDR_W-1:0]    base_q  [SLAVE_NUM];
    logic [ADDR_W-1:0]    limit_q [SLAVE_NUM];
    logic [SLAVE_NUM-1:0] en_q;
    logic                 locked_q;

    logic [SLAVE_NUM-1:0] hit;
    logic [SLAVE_NUM-1:0] sel_d;
    logic [IDX_W-1:0]     idx_d;
    logic                 miss_d;
    logic                 accept;

    assign cfg_locked = locked_q;

    // Region table. A write in the same cycle as the lock request still lands
    // because locked_q is only set at this edge. Out-of-range indices match no
    // entry and are dropped.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < SLAVE_NUM; i++) begin
                base_q[i]  <= '0;
                limit_q[i] <= '0;
            end
            en_q     <= '0;
            locked_q <= 1'b0;
        end else begin
            if (cfg_lock) begin
                locked_q <= 1'b1;
            end
            if (cfg_we && !locked_q) begin
                for (int i = 0; i < SLAVE_NUM; i++) begin
                    if (cfg_idx == IDX_W'(i)) begin
                        base_q[i]  <= cfg_base;
                        limit_q[i] <= cfg_limit;
                        en_q[i]    <= cfg_en;
                    end
                end
            end
        end
    end

    // Half-open [base, limit) check; base >= limit can never satisfy both.
    always_comb begin
        hit = '0;
        for (int i = 0; i < SLAVE_NUM; i++) begin
            hit[i] = en_q[i] && (req_addr >= base_q[i]) && (req_addr < limit_q[i]);
        end
    end

    // Scan from the top down so the lowest matching index is the last writer.
    always_comb begin
        sel_d = '0;
        idx_d = '0;
        for (int i = SLAVE_NUM - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel_d = SLAVE_NUM'(1) << i;
                idx_d = IDX_W'(i);
            end
        end
    end

    assign miss_d    = ~|hit;
    assign req_ready = !dec_valid || dec_ready;
    assign accept    = req_valid && req_ready;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            dec_valid <= 1'b0;
            dec_sel   <= '0;
            dec_idx   <= '0;
            dec_err   <= 1'b0;
            dec_addr  <= '0;
            dec_id    <= '0;
        end else if (accept) begin
            dec_valid <= 1'b1;
            dec_sel   <= sel_d;
            dec_idx   <= idx_d;
            dec_err   <= miss_d;
            dec_addr  <= req_addr;
            dec_id    <= req_id;
        end else if (dec_ready) begin
            dec_valid <= 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (accept && miss_d && (err_cnt != '1)) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

`ifdef ADDR_DECODE_HIT_CNT_EN
    for (genvar g = 0; g < SLAVE_NUM; g++) begin : g_hit_cnt
        logic [CNT_W-1:0] cnt_q;

        // Only the winning region counts, so overlaps are not double counted.
        always_ff @(posedge ACLK or negedge ARESETn) begin
            if (!ARESETn) begin
                cnt_q <= '0;
            end else if (err_clr) begin
                cnt_q <= '0;
            end else if (accept && sel_d[g] && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end

        assign hit_cnt[g*CNT_W +: CNT_W] = cnt_q;
    end
`else
    assign hit_cnt = '0;
`endif

endmodule

// File: tb/tb_slave_addr_decoder.sv
// tb/tb_slave_addr_decoder.sv - self-checking bench for slave_addr_decoder

module tb_slave_addr_decoder;

    logic         ACLK = 1'b0;
    logic         ARESETn;
    logic         cfg_we;
    logic [2:0]   cfg_idx;
    logic [31:0]  cfg_base;
    logic [31:0]  cfg_limit;
    logic         cfg_en;
    logic         cfg_lock;
    logic         cfg_locked;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_addr;
    logic [3:0]   req_id;
    logic         dec_valid;
    logic         dec_ready;
    logic [7:0]   dec_sel;
    logic [2:0]   dec_idx;
    logic         dec_err;
    logic [31:0]  dec_addr;
    logic [3:0]   dec_id;
    logic         err_clr;
    logic [15:0]  err_cnt;
    logic [127:0] hit_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  id;
        logic [7:0]  sel;
        logic [2:0]  idx;
        logic        err;
    } vec_t;

    vec_t sb[$];
    vec_t vecs[11];

    slave_addr_decoder dut (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_base   (cfg_base),
        .cfg_limit  (cfg_limit),
        .cfg_en     (cfg_en),
        .cfg_lock   (cfg_lock),
        .cfg_locked (cfg_locked),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_id     (req_id),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .dec_sel    (dec_sel),
        .dec_idx    (dec_idx),
        .dec_err    (dec_err),
        .dec_addr   (dec_addr),
        .dec_id     (dec_id),
        .err_clr    (err_clr),
        .err_cnt    (err_cnt),
        .hit_cnt    (hit_cnt)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Result handshake completes at the next rising edge; compare in order.
    always @(negedge ACLK) begin
        if (ARESETn && dec_valid && dec_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 128'(dec_id), 128'hFFFF);
            end else begin
                vec_t e;
                e = sb.pop_front();
                chk("dec_id",   128'(dec_id),   128'(e.id));
                chk("dec_addr", 128'(dec_addr), 128'(e.addr));
                chk("dec_sel",  128'(dec_sel),  128'(e.sel));
                chk("dec_idx",  128'(dec_idx),  128'(e.idx));
                chk("dec_err",  128'(dec_err),  128'(e.err));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [3:0] id,
                        input logic [7:0] s, input logic [2:0] ix, input logic e);
        int n = 0;
        vec_t v;
        req_valid = 1'b1;
        req_addr  = a;
        req_id    = id;
        @(negedge ACLK);
        while (!req_ready && n < 50) begin
            n++;
            @(negedge ACLK);
        end
        if (!req_ready) begin
            chk("send_timeout", 128'(req_ready), 128'(1));
        end else begin
            v.addr = a; v.id = id; v.sel = s; v.idx = ix; v.err = e;
            sb.push_back(v);
        end
        @(posedge ACLK);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        req_valid = 1'b0;
        while (sb.size() != 0 && n < 100) begin
            n++;
            @(posedge ACLK);
        end
        #1;
        chk("drain_left", 128'(sb.size()), 128'(0));
    endtask

    task automatic cfg_write(input logic [2:0] idx, input logic [31:0] b,
                             input logic [31:0] l, input logic en);
        cfg_we = 1'b1; cfg_idx = idx; cfg_base = b; cfg_limit = l; cfg_en = en;
        @(posedge ACLK);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge ACLK);
        #1;
        err_clr = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_miss;
        logic [127:0] exp_hits;

        ARESETn = 1'b0; cfg_we = 0; cfg_idx = 0; cfg_base = 0; cfg_limit = 0;
        cfg_en = 0; cfg_lock = 0; req_valid = 0; req_addr = 0; req_id = 0;
        dec_ready = 1'b1; err_clr = 0;

        repeat (2) @(posedge ACLK);
        #1;
        chk("rst_dec_valid", 128'(dec_valid), 0);
        chk("rst_locked",    128'(cfg_locked), 0);
        chk("rst_sel",       128'(dec_sel), 0);
        chk("rst_addr",      128'(dec_addr), 0);
        chk("rst_err_cnt",   128'(err_cnt), 0);
        chk("rst_hit_cnt",   hit_cnt, 0);
        chk("rst_req_ready", 128'(req_ready), 1);
        ARESETn = 1'b1;
        @(posedge ACLK);
        #1;

        cfg_write(3'd0, 32'h0000_0000, 32'h0000_4000, 1'b1);
        cfg_write(3'd7, 32'h8000_0000, 32'h8800_0000, 1'b1);
        cfg_write(3'd1, 32'h0000_8000, 32'h0000_8100, 1'b1);
        cfg_write(3'd2, 32'h0000_8010, 32'h0000_8020, 1'b1);
        cfg_write(3'd3, 32'h0001_0000, 32'h0002_0000, 1'b1);
        cfg_write(3'd4, 32'h0000_A000, 32'h0000_9000, 1'b1);
        cfg_write(3'd6, 32'h0005_0000, 32'h0006_0000, 1'b0);

        vecs[0]  = '{32'h0000_3FFC, 4'd1,  8'h01, 3'd0, 1'b0};
        vecs[1]  = '{32'h0000_4000, 4'd2,  8'h00, 3'd0, 1'b1};
        vecs[2]  = '{32'h87FF_FFFC, 4'd3,  8'h80, 3'd7, 1'b0};
        vecs[3]  = '{32'h8800_0000, 4'd4,  8'h00, 3'd0, 1'b1};
        vecs[4]  = '{32'h0000_8014, 4'd5,  8'h02, 3'd1, 1'b0};
        vecs[5]  = '{32'h0000_8020, 4'd6,  8'h02, 3'd1, 1'b0};
        vecs[6]  = '{32'h0000_8100, 4'd7,  8'h00, 3'd0, 1'b1};
        vecs[7]  = '{32'h8000_0000, 4'd8,  8'h80, 3'd7, 1'b0};
        vecs[8]  = '{32'h0000_A000, 4'd9,  8'h00, 3'd0, 1'b1};
        vecs[9]  = '{32'h0005_0000, 4'd10, 8'h00, 3'd0, 1'b1};
        vecs[10] = '{32'h0000_0000, 4'd11, 8'h01, 3'd0, 1'b0};

        exp_miss = 0;
        for (int i = 0; i < 11; i++) begin
            send(vecs[i].addr, vecs[i].id, vecs[i].sel, vecs[i].idx, vecs[i].err);
            if (vecs[i].err) exp_miss++;
        end
        drain();
        chk("err_cnt_table", 128'(err_cnt), 128'(exp_miss));

        pulse_clr();
        chk("err_cnt_clr", 128'(err_cnt), 0);
        chk("hit_cnt_clr", hit_cnt, 0);
        for (int k = 0; k < 5; k++) begin
            send(32'h0001_0000 + 32'(k * 4), 4'(k), 8'h08, 3'd3, 1'b0);
        end
        drain();
`ifdef ADDR_DECODE_HIT_CNT_EN
        exp_hits = 128'(5) << 48;
`else
        exp_hits = '0;
`endif
        chk("hit_cnt_r3", hit_cnt, exp_hits);

        // Backpressure: first result must hold while the second waits.
        dec_ready = 1'b0;
        send(32'h0000_3000, 4'd12, 8'h01, 3'd0, 1'b0);
        fork
            begin
                send(32'h8700_0000, 4'd13, 8'h80, 3'd7, 1'b0);
                send(32'h0000_8018, 4'd14, 8'h02, 3'd1, 1'b0);
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge ACLK);
                    chk("stall_req_ready", 128'(req_ready), 0);
                    chk("stall_dec_valid", 128'(dec_valid), 1);
                    chk("stall_dec_id",    128'(dec_id), 128'(12));
                    chk("stall_dec_addr",  128'(dec_addr), 128'h3000);
                end
                @(posedge ACLK);
                #1;
                dec_ready = 1'b1;
            end
        join
        drain();

        // Write in the lock cycle commits; later writes are dropped.
        cfg_lock = 1'b1;
        cfg_write(3'd5, 32'h0003_0000, 32'h0003_0100, 1'b1);
        cfg_lock = 1'b0;
        chk("locked_set", 128'(cfg_locked), 1);
        cfg_write(3'd0, 32'h0, 32'h0, 1'b1);
        chk("locked_sticky", 128'(cfg_locked), 1);
        send(32'h0000_0100, 4'd1, 8'h01, 3'd0, 1'b0);
        send(32'h0003_0010, 4'd2, 8'h20, 3'd5, 1'b0);
        drain();

        // Reset with a held result pending.
        dec_ready = 1'b0;
        send(32'h0000_0100, 4'd3, 8'h01, 3'd0, 1'b0);
        req_valid = 1'b0;
        ARESETn = 1'b0;
        #2;
        chk("mid_rst_valid",  128'(dec_valid), 0);
        chk("mid_rst_locked", 128'(cfg_locked), 0);
        chk("mid_rst_sel",    128'(dec_sel), 0);
        chk("mid_rst_id",     128'(dec_id), 0);
        chk("mid_rst_addr",   128'(dec_addr), 0);
        sb.delete();
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        dec_ready = 1'b1;
        send(32'h0000_0100, 4'd4, 8'h00, 3'd0, 1'b1);
        drain();
        chk("post_rst_err_cnt", 128'(err_cnt), 1);

        pulse_clr();
        for (int k = 0; k < 16'hFFFF; k++) begin
            send(32'hFFFF_0000, 4'd0, 8'h00, 3'd0, 1'b1);
        end
        drain();
        chk("err_cnt_full", 128'(err_cnt), 128'hFFFF);
        send(32'hFFFF_0000, 4'd1, 8'h00, 3'd0, 1'b1);
        drain();
        chk("err_cnt_sat", 128'(err_cnt), 128'hFFFF);
        err_clr = 1'b1;
        send(32'hFFFF_0000, 4'd2, 8'h00, 3'd0, 1'b1);
        err_clr = 1'b0;
        drain();
        chk("err_clr_prio", 128'(err_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
